// File: rtl/ysyx_22041461_macro_pkg.sv
// Shared IFU constants: FSM state encoding, default reset PC and the NOP word
// that the instruction register holds out of reset.
package ysyx_22041461_macro_pkg;

  localparam logic [1:0] IFU_IDLE = 2'd0;
  localparam logic [1:0] IFU_REQ  = 2'd1;
  localparam logic [1:0] IFU_WAIT = 2'd2;
  localparam logic [1:0] IFU_HOLD = 2'd3;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  // Sequential successor of a fetch address; the add wraps modulo 2^64.
  function automatic logic [63:0] ifu_seq_pc(input logic [63:0] cur_pc);
    return cur_pc + 64'd4;
  endfunction

endpackage

// File: rtl/ysyx_22041461_Reg.sv
// Generic register with synchronous active-high reset and write enable,
// used by the IFU for its PC, instruction and decode-side pc registers.
module ysyx_22041461_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_22041461_ifu.sv
// Instruction fetch unit: one outstanding fetch, a holding slot toward decode,
// and redirect handling that drops in-flight responses.
// Optional performance counters are enabled by YSYX_22041461_IFU_PERF_EN.
module ysyx_22041461_ifu
  import ysyx_22041461_macro_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req_valid,
  input  logic        fetch_req_ready,
  output logic [63:0] fetch_addr,
  input  logic        fetch_rsp_valid,
  input  logic [31:0] fetch_rsp_data,
  output logic        IF_valid_out,
  output logic [31:0] inst,
  output logic [63:0] pc,
  input  logic        ID_ready,
  input  logic        IF_ctrl,
  input  logic [63:0] next_pc
`ifdef YSYX_22041461_IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_drop_cnt
`endif
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        drop;
  logic        drop_nxt;
  logic [63:0] redir_pc;
  logic [63:0] redir_pc_nxt;
  logic [63:0] pc_reg;
  logic [63:0] pc_din;
  logic        pc_wen;
  logic        capture;

  ysyx_22041461_Reg #(.WIDTH(64), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .wen  (pc_wen),
    .din  (pc_din),
    .dout (pc_reg)
  );

  ysyx_22041461_Reg #(.WIDTH(32), .RESET_VAL(IFU_NOP)) u_inst_reg (
    .clk  (clk),
    .rst  (rst),
    .wen  (capture),
    .din  (fetch_rsp_data),
    .dout (inst)
  );

  ysyx_22041461_Reg #(.WIDTH(64), .RESET_VAL(RESET_PC)) u_out_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .wen  (capture),
    .din  (pc_reg),
    .dout (pc)
  );

  assign fetch_req_valid = (state == IFU_REQ);
  assign fetch_addr      = pc_reg;
  assign IF_valid_out    = (state == IFU_HOLD);

  // A redirect during REQ/WAIT cannot touch pc_reg (the request must stay
  // stable), so the target is parked in redir_pc and applied on the drop.
  always_comb begin
    state_nxt    = state;
    drop_nxt     = drop;
    redir_pc_nxt = redir_pc;
    pc_wen       = 1'b0;
    pc_din       = pc_reg;
    capture      = 1'b0;
    case (state)
      IFU_IDLE: begin
        state_nxt = IFU_REQ;
        if (IF_ctrl) begin
          pc_wen = 1'b1;
          pc_din = next_pc;
        end
      end
      IFU_REQ: begin
        if (IF_ctrl) begin
          drop_nxt     = 1'b1;
          redir_pc_nxt = next_pc;
        end
        if (fetch_req_ready) begin
          state_nxt = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (fetch_rsp_valid) begin
          if (drop || IF_ctrl) begin
            state_nxt = IFU_REQ;
            drop_nxt  = 1'b0;
            pc_wen    = 1'b1;
            pc_din    = IF_ctrl ? next_pc : redir_pc;
          end else begin
            state_nxt = IFU_HOLD;
            capture   = 1'b1;
          end
        end else if (IF_ctrl) begin
          drop_nxt     = 1'b1;
          redir_pc_nxt = next_pc;
        end
      end
      IFU_HOLD: begin
        if (IF_ctrl) begin
          state_nxt = IFU_REQ;
          pc_wen    = 1'b1;
          pc_din    = next_pc;
        end else if (ID_ready) begin
          state_nxt = IFU_REQ;
          pc_wen    = 1'b1;
          pc_din    = ifu_seq_pc(pc_reg);
        end
      end
      default: state_nxt = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IFU_IDLE;
      drop     <= 1'b0;
      redir_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      drop     <= drop_nxt;
      redir_pc <= redir_pc_nxt;
    end
  end

`ifdef YSYX_22041461_IFU_PERF_EN
  logic fetch_evt;
  logic drop_evt;

  // A HOLD handshake counts as a fetch even when it coincides with a redirect.
  assign fetch_evt = (state == IFU_HOLD) && ID_ready;
  assign drop_evt  = (state == IFU_WAIT) && fetch_rsp_valid && (drop || IF_ctrl);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_drop_cnt  <= 64'd0;
    end else begin
      if (fetch_evt) begin
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      end
      if (drop_evt) begin
        perf_drop_cnt <= perf_drop_cnt + 64'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// Directed self-checking bench for ysyx_22041461_ifu; counter checks apply
// when YSYX_22041461_IFU_PERF_EN is defined.
module tb_ysyx_22041461_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_valid;
  logic        fetch_req_ready;
  logic [63:0] fetch_addr;
  logic        fetch_rsp_valid;
  logic [31:0] fetch_rsp_data;
  logic        IF_valid_out;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        ID_ready;
  logic        IF_ctrl;
  logic [63:0] next_pc;
`ifdef YSYX_22041461_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_drop_cnt;
`endif

  int asserts  = 0;
  int failures = 0;

  ysyx_22041461_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_addr      (fetch_addr),
    .fetch_rsp_valid (fetch_rsp_valid),
    .fetch_rsp_data  (fetch_rsp_data),
    .IF_valid_out    (IF_valid_out),
    .inst            (inst),
    .pc              (pc),
    .ID_ready        (ID_ready),
    .IF_ctrl         (IF_ctrl),
    .next_pc         (next_pc)
`ifdef YSYX_22041461_IFU_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_drop_cnt   (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic rdy, input logic rv,
                               input logic [31:0] rd, input logic idr,
                               input logic ctl, input logic [63:0] npc);
    rst             = r;
    fetch_req_ready = rdy;
    fetch_rsp_valid = rv;
    fetch_rsp_data  = rd;
    ID_ready        = idr;
    IF_ctrl         = ctl;
    next_pc         = npc;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    asserts++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    checkOutput("rst_req_valid", {63'd0, fetch_req_valid}, 64'd0);
    checkOutput("rst_if_valid", {63'd0, IF_valid_out}, 64'd0);
    checkOutput("rst_inst", {32'd0, inst}, 64'h13);
    checkOutput("rst_pc", pc, 64'h8000_0000);

    // Reset release, first fetch and response one cycle after acceptance.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("first_req_valid", {63'd0, fetch_req_valid}, 64'd1);
    checkOutput("first_addr", fetch_addr, 64'h8000_0000);
    tick();
    checkOutput("wait_no_req", {63'd0, fetch_req_valid}, 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0093, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("hold_valid", {63'd0, IF_valid_out}, 64'd1);
    checkOutput("hold_inst", {32'd0, inst}, 64'h93);
    checkOutput("hold_pc", pc, 64'h8000_0000);

    // Decode stalls five cycles, the late response pulse must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", {63'd0, IF_valid_out}, 64'd1);
      checkOutput("stall_inst", {32'd0, inst}, 64'h93);
      checkOutput("stall_pc", pc, 64'h8000_0000);
      checkOutput("stall_no_req", {63'd0, fetch_req_valid}, 64'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    tick();
    checkOutput("seq_req_valid", {63'd0, fetch_req_valid}, 64'd1);
    checkOutput("seq_addr", fetch_addr, 64'h8000_0004);
    checkOutput("seq_if_valid", {63'd0, IF_valid_out}, 64'd0);

    // Redirect in WAIT, response one cycle later is dropped.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0100);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("wdrop_if_valid", {63'd0, IF_valid_out}, 64'd0);
    checkOutput("wdrop_req_valid", {63'd0, fetch_req_valid}, 64'd1);
    checkOutput("wdrop_addr", fetch_addr, 64'h8000_0100);
    checkOutput("wdrop_inst_kept", {32'd0, inst}, 64'h93);
`ifdef YSYX_22041461_IFU_PERF_EN
    checkOutput("wdrop_cnt", perf_drop_cnt, 64'd1);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0020_0113, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("redir_inst", {32'd0, inst}, 64'h0020_0113);
    checkOutput("redir_pc", pc, 64'h8000_0100);
`ifdef YSYX_22041461_IFU_PERF_EN
    checkOutput("fetch_cnt_1", perf_fetch_cnt, 64'd1);
`endif

    // Redirect while the request is back-pressured.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    tick();
    checkOutput("bp_addr0", fetch_addr, 64'h8000_0104);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0200);
    tick();
    checkOutput("bp_valid_held", {63'd0, fetch_req_valid}, 64'd1);
    checkOutput("bp_addr_held", fetch_addr, 64'h8000_0104);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("bp_wait", {63'd0, fetch_req_valid}, 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("bp_drop_if_valid", {63'd0, IF_valid_out}, 64'd0);
    checkOutput("bp_new_addr", fetch_addr, 64'h8000_0200);
`ifdef YSYX_22041461_IFU_PERF_EN
    checkOutput("bp_drop_cnt", perf_drop_cnt, 64'd2);
`endif

    // Fetch at 0x80000200, then redirect from HOLD without a handshake.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0030_0113, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("h200_pc", pc, 64'h8000_0200);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0008);
    tick();
    checkOutput("hredir_addr", fetch_addr, 64'h8000_0008);
    checkOutput("hredir_if_valid", {63'd0, IF_valid_out}, 64'd0);
`ifdef YSYX_22041461_IFU_PERF_EN
    checkOutput("hredir_fetch_cnt", perf_fetch_cnt, 64'd2);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0040_0113, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("h008_pc", pc, 64'h8000_0008);
    checkOutput("h008_inst", {32'd0, inst}, 64'h0040_0113);

    // Redirect coinciding with the decode handshake.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h8000_0040);
    tick();
    checkOutput("hs_redir_addr", fetch_addr, 64'h8000_0040);
`ifdef YSYX_22041461_IFU_PERF_EN
    checkOutput("hs_redir_fetch_cnt", perf_fetch_cnt, 64'd3);
`endif

    // Redirect and response in the same WAIT cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b1, 64'h8000_0080);
    tick();
    checkOutput("same_drop_if_valid", {63'd0, IF_valid_out}, 64'd0);
    checkOutput("same_drop_addr", fetch_addr, 64'h8000_0080);
`ifdef YSYX_22041461_IFU_PERF_EN
    checkOutput("same_drop_cnt", perf_drop_cnt, 64'd3);
`endif

    // Reset asserted in WAIT, late response right after release.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("pre_rst_wait", {63'd0, fetch_req_valid}, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("mid_rst_req_valid", {63'd0, fetch_req_valid}, 64'd0);
    checkOutput("mid_rst_pc", pc, 64'h8000_0000);
    checkOutput("mid_rst_inst", {32'd0, inst}, 64'h13);
`ifdef YSYX_22041461_IFU_PERF_EN
    checkOutput("mid_rst_fetch_cnt", perf_fetch_cnt, 64'd0);
    checkOutput("mid_rst_drop_cnt", perf_drop_cnt, 64'd0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("late_rsp_req_valid", {63'd0, fetch_req_valid}, 64'd1);
    checkOutput("late_rsp_addr", fetch_addr, 64'h8000_0000);
    checkOutput("late_rsp_if_valid", {63'd0, IF_valid_out}, 64'd0);
    checkOutput("late_rsp_inst", {32'd0, inst}, 64'h13);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("post_rst_valid", {63'd0, IF_valid_out}, 64'd1);
    checkOutput("post_rst_inst", {32'd0, inst}, 64'h99);

    // PC wraps past the top of the address space.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    checkOutput("wrap_top_addr", fetch_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_00AA, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    tick();
    checkOutput("wrap_addr", fetch_addr, 64'h0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22041461_ifu.md
YSYX_22041461_IFU -- requirements
Module: ysyx_22041461_IFU

Interface
REQ-001 SHALL have parameter: RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have ports: fetch_req_valid  out  1; fetch_req_ready  in  1; fetch_addr  out  64  instruction address.
REQ-005 SHALL have ports: fetch_rsp_valid  in  1; fetch_rsp_data  in  32  instruction word.
REQ-006 SHALL have ports: IF_valid_out  out  1; inst  out  32; pc  out  64, which feed the decode stage.
REQ-007 SHALL have ports: ID_ready  in  1  decode accepts; IF_ctrl  in  1  redirect; next_pc  in  64  redirect target.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, HOLD.
REQ-009 SHALL have these transitions:
- IDLE->REQ: unconditionally.
- REQ->WAIT: when fetch_req_valid && fetch_req_ready.
- WAIT->HOLD: when fetch_rsp_valid and no drop.
- HOLD->REQ: when IF_valid_out && ID_ready.
REQ-010 SHALL assert fetch_req_valid only in REQ, with fetch_addr equal to the PC register.
REQ-011 SHALL hold fetch_req_valid and fetch_addr stable until accepted, including across a redirect.
REQ-012 SHALL capture fetch_rsp_data into the inst register in the WAIT cycle where fetch_rsp_valid is high.
REQ-013 SHALL make IF_valid_out=1 in the cycle after that capture; IF_valid_out SHALL equal (state==HOLD).
REQ-014 SHALL hold inst and pc stable while in HOLD.
REQ-015 SHALL update PC to pc+4 on a HOLD handshake without redirect (64-bit add, wraps modulo 2^64).
REQ-016 SHALL, when IF_ctrl=1 in IDLE or HOLD, load PC=next_pc; from HOLD the FSM goes to REQ and the held instruction is discarded.
REQ-017 SHALL, when IF_ctrl=1 in HOLD coinciding with ID_ready, load PC=next_pc (not pc+4); the current instruction counts as consumed.
REQ-018 SHALL, when IF_ctrl=1 in REQ or WAIT:
- latch next_pc;
- set a drop flag;
- discard the outstanding response on arrival (WAIT->REQ, IF_valid_out stays 0);
- issue the next request at the latched PC.
REQ-019 SHALL drop the response when redirect and fetch_rsp_valid occur in the same WAIT cycle.
REQ-020 SHALL apply only the latest redirect when several arrive before the response; only one drop occurs.
REQ-021 SHALL leave at most one fetch request outstanding.
REQ-022 SHALL ignore fetch_rsp_valid outside WAIT.

Reset
REQ-023 SHALL, while rst=1, set: state=IDLE, PC=RESET_PC, inst=32'h0000_0013, pc=RESET_PC, drop=0, fetch_req_valid=0, IF_valid_out=0.
REQ-024 SHALL abandon an outstanding request on reset mid-operation; a late response arriving after reset is ignored per REQ-022.
REQ-025 SHALL issue the first request (fetch_req_valid=1) in the second cycle after rst deasserts.

Configuration
REQ-026 SHALL, when YSYX_22041461_IFU_PERF_EN is defined:
- add outputs perf_fetch_cnt (64 bits, increments per HOLD handshake);
- add perf_drop_cnt (64 bits, increments per dropped response);
- clear both on reset.
REQ-027 SHALL, when YSYX_22041461_IFU_PERF_EN is undefined, omit those ports and counters; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state encoding, RESET_PC default and NOP encoding in the shared ysyx_22041461_macro include.
REQ-029 SHALL instantiate sub-module ysyx_22041461_Reg (parameterized width, reset value, write enable) for the PC and inst registers.

Verification
REQ-030 SHALL cover reset release with fetch_req_ready=1 and a response 1 cycle later with data 0x00000093:
- fetch_addr=0x80000000;
- IF_valid_out=1 with inst=0x00000093, pc=0x80000000.
REQ-031 SHALL cover ID_ready=0 for 5 cycles in HOLD: inst and pc stay stable and no new request issues; then ID_ready=1 -> next fetch_addr=0x80000004.
REQ-032 SHALL cover IF_ctrl=1, next_pc=0x80000100 in WAIT:
- the response is dropped with IF_valid_out=0;
- the next fetch_addr=0x80000100;
- perf_drop_cnt=1.
REQ-033 SHALL cover redirect while fetch_req_ready=0 in REQ:
- fetch_addr stays at the old value until accepted;
- that response is dropped;
- the following request uses next_pc.
REQ-034 SHALL cover IF_ctrl=1 with ID_ready=1 in HOLD at pc=0x80000008, next_pc=0x80000040: the next fetch_addr=0x80000040 and perf_fetch_cnt increments.
REQ-035 SHALL cover rst=1 asserted in WAIT followed by a late response: the response is ignored and the first post-reset fetch_addr=0x80000000.
